// File: rtl/seq_arith_pkg.sv
// Shared types for the sequential chunked adder: controller states and
// the operation-mode encoding seen on the sub input.
package seq_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice: the generalised byte adder that the
// sequential wrapper reuses once per slice.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_top
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // The top bit's sum is a ^ b ^ carry_in, so its carry-in falls out for free
    // and this still works when CHUNK is 1.
    assign c_top = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit: one CHUNK-bit slice per cycle,
// LSB first, carry rippled through a register, valid/ready on both sides.
module seq_chunk_adder
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_car,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             out_car,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             slice_cout;
    logic             slice_ctop;
    logic             accept;
    logic             last_slice;

    assign accept     = in_valid && in_ready;
    assign last_slice = (idx == IDX_W'(NCHUNK - 1));

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (a_slice),
        .b     (b_slice),
        .cin   (carry_reg),
        .s     (s_slice),
        .cout  (slice_cout),
        .c_top (slice_ctop)
    );

    // sum_next is the full result with the current slice merged in, so the
    // zero flag can be registered on the same edge as the final slice.
    always_comb begin
        a_slice  = a_reg[idx*CHUNK +: CHUNK];
        b_slice  = b_reg[idx*CHUNK +: CHUNK];
        sum_next = sum;
        sum_next[idx*CHUNK +: CHUNK] = s_slice;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is x + ~y + ~borrow_in, so the inverted operand and carry
    // are fixed at accept time and RUN only ever adds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            out_car   <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= x;
                        b_reg     <= (sub == OP_SUB) ? ~y : y;
                        carry_reg <= in_car ^ sub;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum       <= sum_next;
                    carry_reg <= slice_cout;
                    if (last_slice) begin
                        out_car  <= slice_cout;
                        overflow <= slice_ctop ^ slice_cout;
                        zero     <= ~|sum_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
